rbm_cd1_sequencer: RTL and testbench

- Top-level control FSM for one CD-1 training step.
- Positive phase: sweeps the hidden GEMV core over every hidden unit for each frame of a batch, optionally Bernoulli-samples each p_j with an LFSR word, writes the results to the hidden-probability buffer, and strobes the outer-product accumulator once per frame.
- Negative phase: repeats the same sequence with neg_phase=1, using reconstructed frames supplied upstream.
- Then launches the SGD tile update and reports completion. Sits between the AXI-Lite register shell and the core/accumulator/update datapath.

---
 rtl/rbm_cd1_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_rbm_cd1_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbm_cd1_sequencer.sv
// Control FSM for one CD-1 training step: positive sweep, negative sweep, SGD update.
// Strobes are registered and valid during the state they belong to.
module rbm_cd1_sequencer #(
  parameter int H_DIM   = 64,
  parameter int BATCH_W = 8,
  localparam int HW     = (H_DIM > 1) ? $clog2(H_DIM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [BATCH_W-1:0] batch_len,
  input  logic               sample_en,
  input  logic [15:0]        rnd,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic               core_start,
  input  logic               core_busy,
  input  logic [15:0]        core_p,
  output logic [HW-1:0]      hid_sel,
  output logic               h_we,
  output logic [HW-1:0]      h_addr,
  output logic [15:0]        h_data,
  output logic               acc_clr_pos,
  output logic               acc_clr_neg,
  output logic               acc_neg_phase,
  output logic               acc_sample_valid,
  output logic               acc_last_sample,
  input  logic               acc_done,
  output logic               sgd_start,
  input  logic               sgd_done,
  output logic               busy,
  output logic               done,
  output logic [1:0]         phase
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_WFRAME, S_HSTART, S_HWAIT, S_HSTORE,
    S_ACC, S_WACC, S_SGD, S_WSGD, S_FIN
  } state_t;

  localparam logic [HW-1:0] J_LAST = HW'(H_DIM - 1);

  state_t             state_q;
  logic [BATCH_W-1:0] batch_len_q;
  logic [BATCH_W-1:0] sample_cnt_q;
  logic               sample_en_q;
  logic [HW-1:0]      j_q;
  logic [15:0]        p_q;
  logic               guard_q;
  logic               frame_ready_q;
  logic               core_start_q;
  logic               h_we_q;
  logic               acc_clr_q;
  logic               sample_valid_q;
  logic               last_sample_q;
  logic               sgd_start_q;
  logic               done_q;
  logic               neg_phase_q;
  logic [1:0]         phase_q;
  logic               last_frame_d;
  logic [15:0]        h_data_d;

  assign last_frame_d = (sample_cnt_q == (batch_len_q - BATCH_W'(1)));

  // rnd is consumed in the HSTORE cycle itself, so the sample decision stays combinational.
  assign h_data_d = sample_en_q ? ((rnd < p_q) ? 16'hFFFF : 16'h0000) : p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      batch_len_q    <= '0;
      sample_cnt_q   <= '0;
      sample_en_q    <= 1'b0;
      j_q            <= '0;
      p_q            <= '0;
      guard_q        <= 1'b0;
      frame_ready_q  <= 1'b0;
      core_start_q   <= 1'b0;
      h_we_q         <= 1'b0;
      acc_clr_q      <= 1'b0;
      sample_valid_q <= 1'b0;
      last_sample_q  <= 1'b0;
      sgd_start_q    <= 1'b0;
      done_q         <= 1'b0;
      neg_phase_q    <= 1'b0;
      phase_q        <= 2'd0;
    end else begin
      frame_ready_q  <= 1'b0;
      core_start_q   <= 1'b0;
      h_we_q         <= 1'b0;
      acc_clr_q      <= 1'b0;
      sample_valid_q <= 1'b0;
      last_sample_q  <= 1'b0;
      sgd_start_q    <= 1'b0;
      done_q         <= 1'b0;
      if (abort) begin
        state_q     <= S_IDLE;
        phase_q     <= 2'd0;
        neg_phase_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              batch_len_q <= (batch_len == '0) ? BATCH_W'(1) : batch_len;
              sample_en_q <= sample_en;
              phase_q     <= 2'd1;
              neg_phase_q <= 1'b0;
              acc_clr_q   <= 1'b1;
              state_q     <= S_CLR;
            end
          end
          S_CLR: begin
            sample_cnt_q <= '0;
            state_q      <= S_WFRAME;
          end
          S_WFRAME: begin
            if (frame_valid) begin
              j_q          <= '0;
              core_start_q <= 1'b1;
              state_q      <= S_HSTART;
            end
          end
          S_HSTART: begin
            guard_q <= 1'b1;
            state_q <= S_HWAIT;
          end
          S_HWAIT: begin
            // The core raises busy one cycle late, so the first HWAIT cycle is blind.
            if (guard_q) begin
              guard_q <= 1'b0;
            end else if (!core_busy) begin
              p_q     <= core_p;
              h_we_q  <= 1'b1;
              state_q <= S_HSTORE;
            end
          end
          S_HSTORE: begin
            if (j_q == J_LAST) begin
              frame_ready_q  <= 1'b1;
              sample_valid_q <= 1'b1;
              last_sample_q  <= last_frame_d;
              state_q        <= S_ACC;
            end else begin
              j_q          <= j_q + 1'b1;
              core_start_q <= 1'b1;
              state_q      <= S_HSTART;
            end
          end
          S_ACC: begin
            if (last_sample_q) begin
              state_q <= S_WACC;
            end else begin
              sample_cnt_q <= sample_cnt_q + 1'b1;
              state_q      <= S_WFRAME;
            end
          end
          S_WACC: begin
            if (acc_done) begin
              if (phase_q == 2'd1) begin
                phase_q      <= 2'd2;
                neg_phase_q  <= 1'b1;
                sample_cnt_q <= '0;
                state_q      <= S_WFRAME;
              end else begin
                phase_q     <= 2'd3;
                sgd_start_q <= 1'b1;
                state_q     <= S_SGD;
              end
            end
          end
          S_SGD: begin
            state_q <= S_WSGD;
          end
          S_WSGD: begin
            if (sgd_done) begin
              done_q      <= 1'b1;
              phase_q     <= 2'd0;
              neg_phase_q <= 1'b0;
              state_q     <= S_FIN;
            end
          end
          S_FIN: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign frame_ready      = frame_ready_q;
  assign core_start       = core_start_q;
  assign hid_sel          = j_q;
  assign h_we             = h_we_q;
  assign h_addr           = j_q;
  assign h_data           = h_we_q ? h_data_d : 16'h0000;
  assign acc_clr_pos      = acc_clr_q;
  assign acc_clr_neg      = acc_clr_q;
  assign acc_neg_phase    = neg_phase_q;
  assign acc_sample_valid = sample_valid_q;
  assign acc_last_sample  = last_sample_q;
  assign sgd_start        = sgd_start_q;
  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign phase            = phase_q;

endmodule

// File: tb/tb_rbm_cd1_sequencer.sv
// Randomized bench for rbm_cd1_sequencer with behavioural core/accumulator/SGD responders
// and a transaction-level model of the expected hidden-buffer writes and per-frame strobes.
module tb_rbm_cd1_sequencer;
  localparam int H  = 4;
  localparam int BW = 8;
  localparam int HW = 2;

  logic          clk = 1'b0;
  logic          rst, start, abort, sample_en;
  logic [BW-1:0] batch_len;
  logic [15:0]   rnd = 16'h0000;
  logic          frame_valid, frame_ready, core_start, core_busy;
  logic [15:0]   core_p;
  logic [HW-1:0] hid_sel, h_addr;
  logic          h_we;
  logic [15:0]   h_data;
  logic          acc_clr_pos, acc_clr_neg, acc_neg_phase, acc_sample_valid, acc_last_sample, acc_done;
  logic          sgd_start, sgd_done, busy, done;
  logic [1:0]    phase;

  rbm_cd1_sequencer #(.H_DIM(H), .BATCH_W(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .batch_len(batch_len),
    .sample_en(sample_en), .rnd(rnd), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .core_start(core_start), .core_busy(core_busy), .core_p(core_p), .hid_sel(hid_sel),
    .h_we(h_we), .h_addr(h_addr), .h_data(h_data), .acc_clr_pos(acc_clr_pos),
    .acc_clr_neg(acc_clr_neg), .acc_neg_phase(acc_neg_phase), .acc_sample_valid(acc_sample_valid),
    .acc_last_sample(acc_last_sample), .acc_done(acc_done), .sgd_start(sgd_start),
    .sgd_done(sgd_done), .busy(busy), .done(done), .phase(phase)
  );

  always #5 clk = ~clk;

  int n_checks, n_fail;

  // Stimulus knobs
  int          core_lat = 4;
  logic        fixed_p_en = 1'b0;
  logic [15:0] fixed_p = 16'h0;
  logic        rnd_fixed_en = 1'b0;
  logic [15:0] rnd_fixed = 16'h0;
  logic        stall_req = 1'b0;
  logic        early_en = 1'b0;

  // Observation logs
  logic [15:0]   p_issued[$];
  logic [HW-1:0] cs_sel[$];
  logic [HW-1:0] w_addr[$];
  logic [15:0]   w_data[$];
  logic [15:0]   w_rnd[$];
  logic [1:0]    w_phase[$];
  logic          sv_neg[$];
  logic          sv_last[$];
  int n_cs, n_we, n_sv, n_last, n_clr_pos, n_clr_neg, n_sgd, n_done, n_fr, n_cs_fv_low;
  int max_gap, fr_cyc, cyc, acc_real, sgd_real, acc_at_neg, acc_at_sgd, sgd_at_done;
  int acc_cd, sgd_cd, stall_cd;
  logic [1:0] ph_at_sgd;
  bit gap_armed, seen_neg_cs;

  // GEMV core: busy from the cycle after core_start for core_lat cycles
  int core_left;
  always @(posedge clk) begin
    logic [15:0] pv;
    if (rst) begin
      core_busy <= 1'b0;
      core_left <= 0;
    end else if (core_start) begin
      pv = fixed_p_en ? fixed_p : 16'($urandom);
      core_p    <= pv;
      p_issued.push_back(pv);
      core_busy <= 1'b1;
      core_left <= core_lat;
    end else if (core_busy) begin
      if (core_left <= 1) core_busy <= 1'b0;
      core_left <= core_left - 1;
    end
  end

  // Free-running LFSR stand-in
  always @(posedge clk) begin
    #1;
    rnd = rnd_fixed_en ? rnd_fixed : 16'($urandom);
  end

  // Monitor first, then accumulator / SGD / frame-source responders
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (core_start) begin
        n_cs++;
        cs_sel.push_back(hid_sel);
        if (!frame_valid) n_cs_fv_low++;
        if (gap_armed) begin
          if (cyc - fr_cyc > max_gap) max_gap = cyc - fr_cyc;
          gap_armed = 1'b0;
        end
        if (acc_neg_phase && !seen_neg_cs) begin
          seen_neg_cs = 1'b1;
          acc_at_neg = acc_real;
        end
      end
      if (h_we) begin
        n_we++;
        w_addr.push_back(h_addr);
        w_data.push_back(h_data);
        w_rnd.push_back(rnd);
        w_phase.push_back(phase);
      end
      if (acc_sample_valid) begin
        n_sv++;
        sv_neg.push_back(acc_neg_phase);
        sv_last.push_back(acc_last_sample);
      end
      if (acc_last_sample) n_last++;
      if (frame_ready) begin
        n_fr++;
        if (!acc_last_sample) begin
          gap_armed = 1'b1;
          fr_cyc = cyc;
        end
      end
      if (acc_clr_pos) n_clr_pos++;
      if (acc_clr_neg) n_clr_neg++;
      if (sgd_start) begin
        n_sgd++;
        ph_at_sgd = phase;
        acc_at_sgd = acc_real;
      end
      if (done) begin
        n_done++;
        sgd_at_done = sgd_real;
      end
    end
    acc_done = 1'b0;
    sgd_done = 1'b0;
    if (early_en && h_we) begin
      acc_done = 1'b1;
      sgd_done = 1'b1;
    end
    if (acc_cd > 0) begin
      acc_cd--;
      if (acc_cd == 0) begin acc_done = 1'b1; acc_real++; end
    end
    if (acc_sample_valid && acc_last_sample) acc_cd = 3;
    if (sgd_cd > 0) begin
      sgd_cd--;
      if (sgd_cd == 0) begin sgd_done = 1'b1; sgd_real++; end
    end
    if (sgd_start) sgd_cd = 3;
    if (stall_cd > 0) begin
      stall_cd--;
      if (stall_cd == 0) frame_valid = 1'b1;
    end
    if (frame_ready && stall_req) begin
      frame_valid = 1'b0;
      stall_cd = 5;
      stall_req = 1'b0;
    end
  end

  task automatic clear_logs();
    p_issued.delete(); cs_sel.delete(); w_addr.delete(); w_data.delete();
    w_rnd.delete(); w_phase.delete(); sv_neg.delete(); sv_last.delete();
    n_cs = 0; n_we = 0; n_sv = 0; n_last = 0; n_clr_pos = 0; n_clr_neg = 0;
    n_sgd = 0; n_done = 0; n_fr = 0; n_cs_fv_low = 0; max_gap = 0; gap_armed = 1'b0;
    acc_real = 0; sgd_real = 0; acc_at_neg = -1; acc_at_sgd = -1; sgd_at_done = -1;
    seen_neg_cs = 1'b0; ph_at_sgd = 2'd0; acc_cd = 0; sgd_cd = 0;
  endtask

  // Expected behaviour of a full step of n frames per phase, from the observed stimulus
  function automatic int model_errors(input int n, input logic sen);
    int bad;
    int tot;
    logic [15:0] pv;
    logic [15:0] ev;
    bad = 0;
    tot = 2 * n * H;
    if (w_data.size() != tot || p_issued.size() != tot || cs_sel.size() != tot || sv_neg.size() != 2 * n)
      return -1;
    for (int k = 0; k < tot; k++) begin
      pv = p_issued[k];
      ev = sen ? ((w_rnd[k] < pv) ? 16'hFFFF : 16'h0000) : pv;
      if (w_data[k] !== ev) bad++;
      if (int'(w_addr[k]) != k % H) bad++;
      if (int'(cs_sel[k]) != k % H) bad++;
      if (w_phase[k] !== ((k < n * H) ? 2'd1 : 2'd2)) bad++;
    end
    for (int i = 0; i < 2 * n; i++) begin
      if (sv_neg[i] !== (i >= n)) bad++;
      if (sv_last[i] !== ((i % n) == n - 1)) bad++;
    end
    return bad;
  endfunction

  task automatic run_step(input logic [BW-1:0] bl, input logic sen, input int poke_at, output bit to);
    clear_logs();
    batch_len = bl;
    sample_en = sen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    batch_len = BW'($urandom);
    sample_en = ~sen;
    to = 1'b1;
    for (int c = 1; c < 60000; c++) begin
      if (c == poke_at) begin start = 1'b1; batch_len = 8'd5; end
      else start = 1'b0;
      @(negedge clk);
      if (done) begin to = 1'b0; break; end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    n_checks++; if ({frame_ready, core_start, h_we, acc_clr_pos, acc_clr_neg, acc_sample_valid, acc_last_sample, sgd_start, done} !== 9'b0) begin n_fail++; $display("FAIL reset_strobes: some strobe high, expected all 0"); end
    n_checks++; if ({hid_sel, h_addr, h_data, acc_neg_phase} !== 21'b0) begin n_fail++; $display("FAIL reset_datapath: hid_sel=%0d h_addr=%0d h_data=%h neg=%0b expected all 0", hid_sel, h_addr, h_data, acc_neg_phase); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy=%0b expected 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    bit to;
    int e;
    core_lat = 4; fixed_p_en = 1'b1; fixed_p = 16'h1234; rnd_fixed_en = 1'b0;
    run_step(8'd1, 1'b0, -1, to);
    e = model_errors(1, 1'b0);
    n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: no done within budget"); end
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL basic_model: %0d mismatches (-1 = wrong counts), expected 0", e); end
    n_checks++; if (n_we !== 8) begin n_fail++; $display("FAIL basic_we_count: got %0d expected 8", n_we); end
    n_checks++; if (n_sv !== 2 || n_last !== 2) begin n_fail++; $display("FAIL basic_samples: sv=%0d last=%0d expected 2/2", n_sv, n_last); end
    n_checks++; if (n_clr_pos !== 1 || n_clr_neg !== 1) begin n_fail++; $display("FAIL basic_clears: pos=%0d neg=%0d expected 1/1", n_clr_pos, n_clr_neg); end
    n_checks++; if (n_sgd !== 1 || ph_at_sgd !== 2'd3) begin n_fail++; $display("FAIL basic_sgd: count=%0d phase=%0d expected 1/3", n_sgd, ph_at_sgd); end
    n_checks++; if (n_done !== 1 || n_fr !== 2) begin n_fail++; $display("FAIL basic_done_fr: done=%0d frame_ready=%0d expected 1/2", n_done, n_fr); end
    n_checks++; if (busy !== 1'b0 || phase !== 2'd0) begin n_fail++; $display("FAIL basic_end_idle: busy=%0b phase=%0d expected 0/0", busy, phase); end
    $display("test_basic: writes=%0d samples=%0d done=%0d", n_we, n_sv, n_done);
  endtask

  task automatic test_sampling();
    bit to;
    int ones, zeros;
    core_lat = 2; fixed_p_en = 1'b1; fixed_p = 16'h8000;
    rnd_fixed_en = 1'b1; rnd_fixed = 16'h7FFF;
    @(negedge clk);
    run_step(8'd1, 1'b1, -1, to);
    ones = 0;
    foreach (w_data[k]) if (w_data[k] == 16'hFFFF) ones++;
    n_checks++; if (to || ones !== 8) begin n_fail++; $display("FAIL sample_below: %0d of %0d writes 0xFFFF, expected 8 of 8", ones, n_we); end
    rnd_fixed = 16'h8000;
    @(negedge clk);
    run_step(8'd1, 1'b1, -1, to);
    zeros = 0;
    foreach (w_data[k]) if (w_data[k] == 16'h0000) zeros++;
    n_checks++; if (to || zeros !== 8) begin n_fail++; $display("FAIL sample_equal: %0d of %0d writes 0x0000, expected 8 of 8", zeros, n_we); end
    rnd_fixed_en = 1'b0;
    $display("test_sampling: ones=%0d zeros=%0d", ones, zeros);
  endtask

  task automatic test_stall();
    bit to;
    int e;
    core_lat = 3; fixed_p_en = 1'b0; rnd_fixed_en = 1'b0;
    stall_req = 1'b1;
    run_step(8'd3, 1'($urandom), -1, to);
    e = model_errors(3, 1'b0) < 0 ? -1 : 0;
    n_checks++; if (to || e !== 0) begin n_fail++; $display("FAIL stall_shape: timeout=%0b shape=%0d expected 0/0", to, e); end
    n_checks++; if (n_fr !== 6 || n_sv !== 6 || n_last !== 2) begin n_fail++; $display("FAIL stall_counts: fr=%0d sv=%0d last=%0d expected 6/6/2", n_fr, n_sv, n_last); end
    n_checks++; if (n_cs_fv_low !== 0) begin n_fail++; $display("FAIL stall_core_start: %0d core_start while frame_valid low, expected 0", n_cs_fv_low); end
    n_checks++; if (max_gap !== 6) begin n_fail++; $display("FAIL stall_gap: frame_ready->core_start max %0d cycles, expected 6", max_gap); end
    $display("test_stall: frames=%0d max_gap=%0d", n_fr, max_gap);
  endtask

  task automatic test_zero_batch();
    bit to;
    int e;
    core_lat = 1; fixed_p_en = 1'b0;
    run_step(8'd0, 1'b1, -1, to);
    e = model_errors(1, 1'b1);
    n_checks++; if (to || n_sv !== 2) begin n_fail++; $display("FAIL zero_batch_samples: timeout=%0b sv=%0d expected 0/2", to, n_sv); end
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL zero_batch_model: %0d mismatches, expected 0", e); end
    n_checks++; if (max_gap !== 0) begin n_fail++; $display("FAIL zero_batch_gap: %0d, expected no non-final frame", max_gap); end
    $display("test_zero_batch: samples=%0d", n_sv);
  endtask

  task automatic test_abort();
    bit to, found;
    int e;
    clear_logs();
    core_lat = 3; fixed_p_en = 1'b0;
    batch_len = 8'd1; sample_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (core_start && acc_neg_phase && hid_sel == 2'd2) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL abort_reach: neg-phase j=2 core_start not seen, expected it"); end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || phase !== 2'd0) begin n_fail++; $display("FAIL abort_idle: busy=%0b phase=%0d expected 0/0", busy, phase); end
    n_checks++; if ({frame_ready, core_start, h_we, acc_sample_valid, sgd_start, done} !== 6'b0) begin n_fail++; $display("FAIL abort_strobes: strobe high after abort, expected none"); end
    repeat (30) @(negedge clk);
    n_checks++; if (n_done !== 0 || n_sgd !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_quiet: done=%0d sgd=%0d busy=%0b expected 0/0/0", n_done, n_sgd, busy); end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_beats_start: busy=%0b expected 0", busy); end
    repeat (2) @(negedge clk);
    run_step(8'd1, 1'b1, -1, to);
    e = model_errors(1, 1'b1);
    n_checks++; if (to || e !== 0 || n_done !== 1) begin n_fail++; $display("FAIL abort_restart: timeout=%0b mism=%0d done=%0d expected 0/0/1", to, e, n_done); end
    $display("test_abort: restart done=%0d", n_done);
  endtask

  task automatic test_busy_ignores();
    bit to;
    int e;
    core_lat = 2; fixed_p_en = 1'b0;
    early_en = 1'b1;
    run_step(8'd2, 1'b1, 20, to);
    early_en = 1'b0;
    e = model_errors(2, 1'b1);
    n_checks++; if (to || e !== 0) begin n_fail++; $display("FAIL ignore_model: timeout=%0b mism=%0d expected 0/0", to, e); end
    n_checks++; if (n_sv !== 4 || n_done !== 1 || n_clr_pos !== 1) begin n_fail++; $display("FAIL ignore_counts: sv=%0d done=%0d clr=%0d expected 4/1/1", n_sv, n_done, n_clr_pos); end
    n_checks++; if (acc_at_neg !== 1 || acc_at_sgd !== 2) begin n_fail++; $display("FAIL ignore_early_acc_done: acc_done seen at neg=%0d sgd=%0d expected 1/2", acc_at_neg, acc_at_sgd); end
    n_checks++; if (sgd_at_done !== 1) begin n_fail++; $display("FAIL ignore_early_sgd_done: sgd_done seen at done=%0d expected 1", sgd_at_done); end
    $display("test_busy_ignores: samples=%0d done=%0d", n_sv, n_done);
  endtask

  task automatic test_random();
    bit to;
    int e, bl;
    logic sen;
    fixed_p_en = 1'b0; rnd_fixed_en = 1'b0;
    for (int it = 0; it < 5; it++) begin
      bl = $urandom_range(1, 4);
      sen = 1'($urandom);
      core_lat = $urandom_range(1, 6);
      run_step(BW'(bl), sen, -1, to);
      e = model_errors(bl, sen);
      n_checks++; if (to || e !== 0 || n_done !== 1) begin n_fail++; $display("FAIL random_%0d: bl=%0d sen=%0b timeout=%0b mism=%0d done=%0d expected mism 0 done 1", it, bl, sen, to, e, n_done); end
      $display("test_random %0d: bl=%0d sen=%0b lat=%0d writes=%0d", it, bl, sen, core_lat, n_we);
    end
  endtask

  task automatic test_max_batch();
    bit to;
    int e;
    core_lat = 1; fixed_p_en = 1'b0;
    run_step(8'd255, 1'b1, -1, to);
    e = model_errors(255, 1'b1);
    n_checks++; if (to || n_sv !== 510 || n_last !== 2) begin n_fail++; $display("FAIL max_batch_counts: timeout=%0b sv=%0d last=%0d expected 0/510/2", to, n_sv, n_last); end
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL max_batch_model: %0d mismatches, expected 0", e); end
    $display("test_max_batch: samples=%0d", n_sv);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; batch_len = '0; sample_en = 1'b0;
    frame_valid = 1'b1; acc_done = 1'b0; sgd_done = 1'b0;
    core_busy = 1'b0; core_p = 16'h0;
    clear_logs();
    test_reset();
    test_basic();
    test_sampling();
    test_stall();
    test_zero_batch();
    test_abort();
    test_busy_ignores();
    test_random();
    test_max_batch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
